// File: rtl/sram_pkg.sv
// Shared types and default sizes for the SRAM serial command loader.
package sram_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_RD_TIMEOUT = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIFT   = 3'd1,
    WRITE   = 3'd2,
    READ    = 3'd3,
    WAIT_RD = 3'd4
  } loader_state_t;

  typedef enum logic {
    OP_WRITE = 1'b0,
    OP_READ  = 1'b1
  } loader_op_t;

  // Counter width able to index 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_loader_piso.sv
// Parallel-load, MSB-first serializer with bit counter and last-bit flag.
module sram_loader_piso
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  advance_i,
  output logic                  bit_o,
  output logic                  last_bit_o
);

  localparam int CW = cnt_width(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      sreg_d = data_i;
      cnt_d  = '0;
    end else if (advance_i) begin
      // Zeros fill from the bottom so the line idles low once the word is out.
      sreg_d = sreg_q << 1;
      cnt_d  = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bit_o      = sreg_q[DATA_WIDTH-1];
  assign last_bit_o = (cnt_q == CW'(DATA_WIDTH - 1));

endmodule

// File: rtl/sram_serial_loader.sv
// Command front-end for sram_top: serial writes, handshaked reads with timeout.
// Optional SRAM_LOADER_VERIFY_EN: each write is followed by a read-back compare.
//
// state   | meaning
// IDLE    | req_ready=1, accepts one command
// SHIFT   | DATA_WIDTH cycles of sram_shift, word MSB-first on serial_in
// WRITE   | one cycle sram_w_en
// READ    | one cycle sram_r_en
// WAIT_RD | wait for sram_data_valid, abort after RD_TIMEOUT cycles
module sram_serial_loader
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int RD_TIMEOUT = DEF_RD_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  rsp_valid,
  output logic                  rsp_err,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  sram_serial_in,
  output logic                  sram_shift,
  output logic                  sram_w_en,
  output logic                  sram_r_en,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  input  logic [DATA_WIDTH-1:0] sram_data_out,
  input  logic                  sram_data_valid
);

  localparam int TW = cnt_width(RD_TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(RD_TIMEOUT - 1);

  loader_state_t         state_q, state_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  req_ready_q, req_ready_d;
  logic                  shift_q, shift_d;
  logic                  w_en_q, w_en_d;
  logic                  r_en_q, r_en_d;
  logic                  piso_load, piso_adv, piso_bit, piso_last;
  logic                  accept;

`ifdef SRAM_LOADER_VERIFY_EN
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  verify_q, verify_d;
`endif

  assign accept = req_valid && req_ready_q;

  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    addr_d      = addr_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    piso_load   = 1'b0;
    piso_adv    = 1'b0;
`ifdef SRAM_LOADER_VERIFY_EN
    wdata_d     = wdata_q;
    verify_d    = verify_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d = req_addr;
          if (loader_op_t'(req_op) == OP_READ) begin
            state_d = READ;
`ifdef SRAM_LOADER_VERIFY_EN
            verify_d = 1'b0;
`endif
          end else begin
            state_d   = SHIFT;
            piso_load = 1'b1;
`ifdef SRAM_LOADER_VERIFY_EN
            wdata_d = req_data;
`endif
          end
        end
      end
      SHIFT: begin
        piso_adv = 1'b1;
        if (piso_last) state_d = WRITE;
      end
      WRITE: begin
`ifdef SRAM_LOADER_VERIFY_EN
        state_d  = READ;
        verify_d = 1'b1;
`else
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
`endif
      end
      READ: begin
        state_d = WAIT_RD;
        tmo_d   = '0;
      end
      WAIT_RD: begin
        tmo_d = tmo_q + TW'(1);
        // Data arriving on the final timeout cycle still counts as a good read.
        if (sram_data_valid) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_data_d  = sram_data_out;
`ifdef SRAM_LOADER_VERIFY_EN
          rsp_err_d = verify_q && (sram_data_out != wdata_q);
`endif
        end else if (tmo_q == TMO_LAST) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Pin registers are loaded from the next state so they line up with it.
    req_ready_d = (state_d == IDLE);
    shift_d     = (state_d == SHIFT);
    w_en_d      = (state_d == WRITE);
    r_en_d      = (state_d == READ);
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q     <= IDLE;
      tmo_q       <= '0;
      addr_q      <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      req_ready_q <= 1'b0;
      shift_q     <= 1'b0;
      w_en_q      <= 1'b0;
      r_en_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      addr_q      <= addr_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      req_ready_q <= req_ready_d;
      shift_q     <= shift_d;
      w_en_q      <= w_en_d;
      r_en_q      <= r_en_d;
    end
  end

`ifdef SRAM_LOADER_VERIFY_EN
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wdata_q  <= '0;
      verify_q <= 1'b0;
    end else begin
      wdata_q  <= wdata_d;
      verify_q <= verify_d;
    end
  end
`endif

  sram_loader_piso #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_piso (
    .clk        (clk),
    .arst       (arst),
    .load_i     (piso_load),
    .data_i     (req_data),
    .advance_i  (piso_adv),
    .bit_o      (piso_bit),
    .last_bit_o (piso_last)
  );

  assign req_ready      = req_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_err        = rsp_err_q;
  assign rsp_data       = rsp_data_q;
  assign sram_serial_in = piso_bit;
  assign sram_shift     = shift_q;
  assign sram_w_en      = w_en_q;
  assign sram_r_en      = r_en_q;
  assign sram_addr      = addr_q;

endmodule
